// File: rtl/product_accumulator.sv
// Sums N_TERMS serial unsigned products into one result and holds it on a valid/ready output.
// Optional PRODUCT_ACC_FIRE_EN compiles in the registered threshold comparator driving fire.
module product_accumulator #(
  parameter int unsigned PROD_W    = 10,
  parameter int unsigned N_TERMS   = 4,
  parameter int unsigned ACC_W     = 12,
  parameter int unsigned THRESHOLD = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PROD_W-1:0]          m_res,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_W-1:0]           acc_out,
  output logic [$clog2(N_TERMS)-1:0] term_cnt,
  output logic                       fire
);

  localparam int unsigned CNT_W = $clog2(N_TERMS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_sum;
  logic               beat_acc;

  // First beat of a group loads rather than adds, so a stale sum never carries over.
  always_comb begin
    acc_sum  = (cnt_q == '0) ? ACC_W'(m_res) : acc_q + ACC_W'(m_res);
    beat_acc = in_valid && in_ready;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (clr) begin
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (beat_acc) begin
            acc_d = acc_sum;
            if (cnt_q == LAST_CNT) begin
              cnt_d   = '0;
              state_d = HOLD;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) state_d = ACCUM;
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PRODUCT_ACC_FIRE_EN
  logic fire_q, fire_d;

  // fire is captured with the completing beat and dropped together with out_valid.
  always_comb begin
    fire_d = fire_q;
    if (clr) begin
      fire_d = 1'b0;
    end else if (state_q == ACCUM && beat_acc && cnt_q == LAST_CNT) begin
      fire_d = (acc_sum >= ACC_W'(THRESHOLD));
    end else if (state_q == HOLD && out_ready) begin
      fire_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) fire_q <= 1'b0;
    else     fire_q <= fire_d;
  end

  assign fire = fire_q;
`else
  // Comparator compiled out; the constant term folds away and fire stays 0.
  assign fire = 1'b0 && (THRESHOLD < (1 << ACC_W));
`endif

  assign in_ready  = (state_q == ACCUM) && !clr;
  assign out_valid = (state_q == HOLD);
  assign acc_out   = acc_q;
  assign term_cnt  = cnt_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: stimulus pushes expected results, a monitor pops on each output handshake.
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [9:0]  m_res = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] acc_out;
  logic [1:0]  term_cnt;
  logic        fire;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int sum;
    int fire;
  } exp_t;

  exp_t exp_q[$];

  product_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .m_res     (m_res),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_out   (acc_out),
    .term_cnt  (term_cnt),
    .fire      (fire)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int fire_of(input int s);
`ifdef PRODUCT_ACC_FIRE_EN
    return (s >= 1024) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  task automatic push(input int s);
    exp_t e;
    e.sum  = s;
    e.fire = fire_of(s);
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int v);
    in_valid = 1'b1;
    m_res    = 10'(v);
    #1;
    chk("in_ready_on_beat", int'(in_ready), 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic group4(input int a, input int b, input int c, input int d);
    beat(a);
    beat(b);
    beat(c);
    beat(d);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    #1;
    chk("valid_before_take", int'(out_valid), 1);
    step();
    out_ready = 1'b0;
    chk("valid_after_take", int'(out_valid), 0);
  endtask

  // Monitor: every output handshake must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got %0d, expected no output", acc_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result_sum", int'(acc_out), e.sum);
        chk("result_fire", int'(fire), e.fire);
      end
    end
  end

  initial begin
    // Reset for two cycles
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_acc_out", int'(acc_out), 0);
    chk("rst_term_cnt", int'(term_cnt), 0);
    chk("rst_fire", int'(fire), 0);
    chk("rst_in_ready", int'(in_ready), 1);

    // Basic sum with one-cycle latency
    push(24);
    beat(3);
    beat(5);
    chk("term_cnt_after_2", int'(term_cnt), 2);
    chk("valid_mid_group", int'(out_valid), 0);
    beat(7);
    beat(9);
    chk("basic_valid_latency", int'(out_valid), 1);
    chk("basic_acc", int'(acc_out), 24);
    chk("basic_in_ready_hold", int'(in_ready), 0);
    chk("basic_term_cnt_wrap", int'(term_cnt), 0);
    consume();

    // Maximum products
    push(3844);
    group4(961, 961, 961, 961);
    chk("max_acc", int'(acc_out), 3844);
    chk("max_fire", int'(fire), fire_of(3844));
    consume();
    chk("fire_cleared", int'(fire), 0);

    // Gaps between beats, then backpressure with a beat offered during HOLD
    push(100);
    for (int i = 0; i < 4; i++) begin
      beat((i + 1) * 10);
      step();
      step();
    end
    in_valid = 1'b1;
    m_res    = 10'd55;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_acc", int'(acc_out), 100);
      step();
    end
    in_valid = 1'b0;
    consume();
    chk("bp_acc_kept", int'(acc_out), 100);
    chk("bp_beat_dropped", int'(term_cnt), 0);

    // Back-to-back groups; second checks fresh load
    push(4);
    group4(1, 1, 1, 1);
    consume();
    push(100);
    group4(100, 0, 0, 0);
    chk("fresh_load_acc", int'(acc_out), 100);
    consume();

    // Abort mid-group with a beat presented alongside clr
    beat(50);
    beat(50);
    clr      = 1'b1;
    in_valid = 1'b1;
    m_res    = 10'd50;
    #1;
    chk("clr_in_ready", int'(in_ready), 0);
    step();
    clr      = 1'b0;
    in_valid = 1'b0;
    chk("clr_term_cnt", int'(term_cnt), 0);
    chk("clr_acc", int'(acc_out), 0);
    chk("clr_valid", int'(out_valid), 0);
    push(8);
    group4(2, 2, 2, 2);
    chk("after_clr_acc", int'(acc_out), 8);
    consume();

    // clr in HOLD discards the unconsumed result
    group4(1, 2, 3, 4);
    chk("hold_before_clr", int'(out_valid), 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_hold_valid", int'(out_valid), 0);
    chk("clr_hold_acc", int'(acc_out), 0);

    // Reset during HOLD
    group4(3, 5, 7, 9);
    chk("pre_rst_acc", int'(acc_out), 24);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_acc", int'(acc_out), 0);
    chk("mid_rst_term_cnt", int'(term_cnt), 0);
    chk("mid_rst_fire", int'(fire), 0);
    chk("mid_rst_in_ready", int'(in_ready), 1);

    step();
    step();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
